// File: rtl/memwb_align_stage_if.sv
// MEM->WB handshake bundle: MEM-side request fields and WB-side head fields.
// Latency: none, this is wiring only.
// Backpressure: mem_ready / wb_ready carry the flow control in each direction.
interface memwb_align_stage_if #(
    parameter int XLEN = 32
);
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [2:0]      mem_funct3;
    logic [4:0]      mem_rd_addr;
    logic            mem_is_load;
    logic            mem_regwrite;
    logic            mem_f_regwrite;

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_alu_data;
    logic [XLEN-1:0] wb_load_data;
    logic [4:0]      wb_rd_addr;
    logic            wb_is_load;
    logic            wb_regwrite;
    logic            wb_f_regwrite;
    logic            wb_misalign;

    // Stage side: consumes MEM entries, presents the WB head.
    modport slave (
        input  mem_valid, mem_addr, mem_rdata, mem_funct3, mem_rd_addr,
               mem_is_load, mem_regwrite, mem_f_regwrite, wb_ready,
        output mem_ready, wb_valid, wb_alu_data, wb_load_data, wb_rd_addr,
               wb_is_load, wb_regwrite, wb_f_regwrite, wb_misalign
    );

    // Environment side: produces MEM entries, consumes the WB head.
    modport master (
        output mem_valid, mem_addr, mem_rdata, mem_funct3, mem_rd_addr,
               mem_is_load, mem_regwrite, mem_f_regwrite, wb_ready,
        input  mem_ready, wb_valid, wb_alu_data, wb_load_data, wb_rd_addr,
               wb_is_load, wb_regwrite, wb_f_regwrite, wb_misalign
    );
endinterface

// File: rtl/memwb_align_stage.sv
// MEM->WB stage: load align/extend + misalign detect at accept, 2-entry skid buffer, saturating event counters.
// Latency: 1 cycle from accept to wb_valid when the head slot is free (or frees in the same cycle).
// Backpressure: mem_ready is low only when both entries are full; it depends on state alone, never on wb_ready.
module memwb_align_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    memwb_align_stage_if.slave mw,
    output logic [CNT_W-1:0]   load_cnt,
    output logic [CNT_W-1:0]   misalign_cnt
);
    localparam int OFFW = $clog2(XLEN / 8);

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] ld;
        logic [4:0]      rd;
        logic            is_load;
        logic            regwrite;
        logic            f_regwrite;
        logic            misalign;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           r_state, w_state_nxt;
    entry_t           r_head, r_skid, w_new;
    logic             w_acc, w_pop, w_cnt_en;
    logic             w_head_ld_new, w_head_ld_skid, w_skid_ld;
    logic [2:0]       w_off;
    logic [5:0]       w_shamt;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_word;
    logic [XLEN-1:0]  w_ld;
    logic             w_mis;
    logic [CNT_W-1:0] r_load_cnt, r_mis_cnt;

    // Lane select: shift the addressed byte down to bit 0, then take 8/16/32 bits.
    assign w_off   = 3'(mw.mem_addr[OFFW-1:0]);
    assign w_shamt = {w_off, 3'b000};
    assign w_byte  = 8'(mw.mem_rdata >> w_shamt);
    assign w_half  = 16'(mw.mem_rdata >> w_shamt);
    assign w_word  = 32'(mw.mem_rdata >> w_shamt);

    // Extend the selected lane by funct3 and flag misaligned accesses; non-loads give zero.
    always_comb begin
        w_ld  = '0;
        w_mis = 1'b0;
        if (mw.mem_is_load) begin
            case (mw.mem_funct3)
                3'd0: w_ld = XLEN'($signed(w_byte));
                3'd4: w_ld = XLEN'(w_byte);
                3'd1: begin
                    w_ld  = XLEN'($signed(w_half));
                    w_mis = w_off[0];
                end
                3'd5: begin
                    w_ld  = XLEN'(w_half);
                    w_mis = w_off[0];
                end
                3'd2: begin
                    w_ld  = XLEN'($signed(w_word));
                    w_mis = |w_off[1:0];
                end
                3'd6: begin
                    // LWU only exists on RV64; on RV32 it falls back to raw data.
                    if (XLEN == 64) begin
                        w_ld  = XLEN'(w_word);
                        w_mis = |w_off[1:0];
                    end else begin
                        w_ld = mw.mem_rdata;
                    end
                end
                3'd3: begin
                    // LD keeps the full word; the flag only exists on RV64.
                    w_ld  = mw.mem_rdata;
                    w_mis = (XLEN == 64) && (|w_off);
                end
                default: w_ld = mw.mem_rdata;
            endcase
        end
    end

    // Build the entry to store; write enables are qualified here so WB never sees a faulting write.
    always_comb begin
        w_new            = '0;
        w_new.alu        = mw.mem_addr;
        w_new.ld         = w_ld;
        w_new.rd         = mw.mem_rd_addr;
        w_new.is_load    = mw.mem_is_load;
        w_new.regwrite   = mw.mem_regwrite && (mw.mem_rd_addr != 5'd0) && !w_mis;
        w_new.f_regwrite = mw.mem_f_regwrite && !w_mis;
        w_new.misalign   = w_mis;
    end

    assign w_acc = mw.mem_valid && mw.mem_ready;
    assign w_pop = mw.wb_valid && mw.wb_ready;

    // Occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next occupancy and slot write controls; flush squashes everything, including same-cycle accept/pop.
    always_comb begin
        w_state_nxt    = r_state;
        w_head_ld_new  = 1'b0;
        w_head_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt   = S_ONE;
                    w_head_ld_new = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc && w_pop) begin
                    w_head_ld_new = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = S_TWO;
                    w_skid_ld   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nxt    = S_ONE;
                    w_head_ld_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt    = S_EMPTY;
            w_head_ld_new  = 1'b0;
            w_head_ld_skid = 1'b0;
            w_skid_ld      = 1'b0;
        end
    end

    // Head and skid payload slots; stale contents after flush are masked by wb_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_ld_new)       r_head <= w_new;
            else if (w_head_ld_skid) r_head <= r_skid;
            if (w_skid_ld)           r_skid <= w_new;
        end
    end

    assign w_cnt_en = w_pop && !flush && r_head.is_load;

    // Saturating retire counters; a flushed head is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_cnt <= '0;
            r_mis_cnt  <= '0;
        end else if (w_cnt_en) begin
            if (r_load_cnt != '1)                  r_load_cnt <= r_load_cnt + CNT_W'(1);
            if (r_head.misalign && r_mis_cnt != '1) r_mis_cnt  <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign mw.mem_ready     = (r_state != S_TWO);
    assign mw.wb_valid      = (r_state != S_EMPTY);
    assign mw.wb_alu_data   = r_head.alu;
    assign mw.wb_load_data  = r_head.ld;
    assign mw.wb_rd_addr    = r_head.rd;
    assign mw.wb_is_load    = r_head.is_load;
    assign mw.wb_regwrite   = r_head.regwrite;
    assign mw.wb_f_regwrite = r_head.f_regwrite;
    assign mw.wb_misalign   = r_head.misalign;
    assign load_cnt         = r_load_cnt;
    assign misalign_cnt     = r_mis_cnt;
endmodule

// File: tb/tb_memwb_align_stage.sv
// Bench for memwb_align_stage: one RV32 instance (2-bit counters) and one RV64 instance.
// Expected entries are queued at issue time; monitors compare the WB head every cycle.
// Stimulus is directed with hand-computed load results.
module tb_memwb_align_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  lc32, mc32;
    logic [31:0] lc64, mc64;

    always #5 clk = ~clk;

    memwb_align_stage_if #(.XLEN(32)) b32 ();
    memwb_align_stage_if #(.XLEN(64)) b64 ();

    memwb_align_stage #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .reset(reset), .flush(flush), .mw(b32),
        .load_cnt(lc32), .misalign_cnt(mc32)
    );
    memwb_align_stage #(.XLEN(64), .CNT_W(32)) u64 (
        .clk(clk), .reset(reset), .flush(flush), .mw(b64),
        .load_cnt(lc64), .misalign_cnt(mc64)
    );

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] ld;
        logic [4:0]  rd;
        logic        is_load;
        logic        rw;
        logic        frw;
        logic        mis;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] R64 = 64'h8000_0001_F000_0002;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input bit w64);
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (w64 ? b64.wb_valid : b32.wb_valid)) begin
                if (w64) a = '{alu: b64.wb_alu_data, ld: b64.wb_load_data, rd: b64.wb_rd_addr,
                               is_load: b64.wb_is_load, rw: b64.wb_regwrite,
                               frw: b64.wb_f_regwrite, mis: b64.wb_misalign};
                else     a = '{alu: 64'(b32.wb_alu_data), ld: 64'(b32.wb_load_data), rd: b32.wb_rd_addr,
                               is_load: b32.wb_is_load, rw: b32.wb_regwrite,
                               frw: b32.wb_f_regwrite, mis: b32.wb_misalign};
                if ((w64 ? q64.size() : q32.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s unexpected entry: got %0h expected none", w64 ? "mon64" : "mon32", a);
                end else begin
                    e = w64 ? q64[0] : q32[0];
                    chk(w64 ? "mon64_head" : "mon32_head", 256'(a), 256'(e));
                    if (!flush && (w64 ? b64.wb_ready : b32.wb_ready)) begin
                        if (w64) void'(q64.pop_front());
                        else     void'(q32.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic send(input bit w64, input logic [63:0] addr, input logic [63:0] rdata,
                        input logic [2:0] f3, input logic [4:0] rd, input logic ld,
                        input logic rw, input logic frw, input logic [63:0] eld, input logic emis);
        exp_t e;
        bit   ok;
        e = '{alu: addr, ld: eld, rd: rd, is_load: ld, rw: rw && (rd != 5'd0) && !emis,
              frw: frw && !emis, mis: emis};
        if (w64) begin
            b64.mem_valid = 1'b1; b64.mem_addr = addr; b64.mem_rdata = rdata;
            b64.mem_funct3 = f3; b64.mem_rd_addr = rd; b64.mem_is_load = ld;
            b64.mem_regwrite = rw; b64.mem_f_regwrite = frw;
            q64.push_back(e);
        end else begin
            b32.mem_valid = 1'b1; b32.mem_addr = addr[31:0]; b32.mem_rdata = rdata[31:0];
            b32.mem_funct3 = f3; b32.mem_rd_addr = rd; b32.mem_is_load = ld;
            b32.mem_regwrite = rw; b32.mem_f_regwrite = frw;
            q32.push_back(e);
        end
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = w64 ? b64.mem_ready : b32.mem_ready;
        end
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: mem_ready stayed 0 for 40 cycles, required 1");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
        b64.mem_valid = 1'b0;
        b32.mem_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit w64);
        int n = 0;
        while (n < 50 && ((w64 ? q64.size() : q32.size()) != 0 || (w64 ? b64.wb_valid : b32.wb_valid))) begin
            @(negedge clk);
            n++;
        end
        chk(w64 ? "drain64" : "drain32", 256'(n < 50), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst();
        chk("rst32_rdy", 256'(b32.mem_ready), 256'(1));
        chk("rst32_out", 256'({b32.wb_valid, b32.wb_alu_data, b32.wb_load_data, b32.wb_rd_addr,
                               b32.wb_is_load, b32.wb_regwrite, b32.wb_f_regwrite,
                               b32.wb_misalign, lc32, mc32}), 256'(0));
        chk("rst64_rdy", 256'(b64.mem_ready), 256'(1));
        chk("rst64_out", 256'({b64.wb_valid, b64.wb_alu_data, b64.wb_load_data, b64.wb_rd_addr,
                               b64.wb_is_load, b64.wb_regwrite, b64.wb_f_regwrite,
                               b64.wb_misalign, lc64, mc64}), 256'(0));
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        b32.mem_valid = 1'b0; b32.mem_addr = '0; b32.mem_rdata = '0; b32.mem_funct3 = '0;
        b32.mem_rd_addr = '0; b32.mem_is_load = 1'b0; b32.mem_regwrite = 1'b0;
        b32.mem_f_regwrite = 1'b0; b32.wb_ready = 1'b0;
        b64.mem_valid = 1'b0; b64.mem_addr = '0; b64.mem_rdata = '0; b64.mem_funct3 = '0;
        b64.mem_rd_addr = '0; b64.mem_is_load = 1'b0; b64.mem_regwrite = 1'b0;
        b64.mem_f_regwrite = 1'b0; b64.wb_ready = 1'b0;
        fork
            mon(1'b0);
            mon(1'b1);
        join_none

        #12;
        chk_rst();
        @(negedge clk);
        reset = 1'b1;
        b32.wb_ready = 1'b1;
        b64.wb_ready = 1'b1;
        @(posedge clk);
        #1;

        // RV32 lanes, x0 handling, passthrough, non-load; 7 loads saturate the 2-bit counter.
        send(0, 64'h1003, 64'h80FF7F01, 3'd0, 5'd5, 1, 1, 0, 64'hFFFF_FF80, 0);
        chk("lat1_32", 256'(b32.wb_valid), 256'(1));
        send(0, 64'h1003, 64'h80FF7F01, 3'd4, 5'd6,  1, 1, 0, 64'h0000_0080, 0);
        send(0, 64'h2002, 64'h80FF7F01, 3'd1, 5'd7,  1, 1, 0, 64'hFFFF_80FF, 0);
        send(0, 64'h2001, 64'h80FF7F01, 3'd5, 5'd8,  1, 1, 0, 64'h0000_FF7F, 1);
        send(0, 64'h3000, 64'h80FF7F01, 3'd2, 5'd0,  1, 1, 0, 64'h80FF_7F01, 0);
        send(0, 64'h3000, 64'h80FF7F01, 3'd2, 5'd0,  1, 0, 1, 64'h80FF_7F01, 0);
        send(0, 64'h3001, 64'h12345678, 3'd3, 5'd9,  1, 1, 0, 64'h1234_5678, 0);
        send(0, 64'h1234, 64'hDEADBEEF, 3'd2, 5'd10, 0, 1, 0, 64'h0, 0);
        wait_drain(0);
        chk("cnt32_sat", 256'({lc32, mc32}), 256'({2'd3, 2'd1}));

        // RV64 lanes: LWU, LW, misaligned LD, sign/zero cases, passthrough, misaligned LW.
        send(1, 64'h4,  R64, 3'd6, 5'd1, 1, 1, 0, 64'h0000_0000_8000_0001, 0);
        send(1, 64'h0,  R64, 3'd2, 5'd2, 1, 1, 0, 64'hFFFF_FFFF_F000_0002, 0);
        send(1, 64'h3,  R64, 3'd3, 5'd3, 1, 1, 0, R64, 1);
        send(1, 64'h7,  R64, 3'd0, 5'd4, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF80, 0);
        send(1, 64'h6,  R64, 3'd1, 5'd5, 1, 1, 0, 64'hFFFF_FFFF_FFFF_8000, 0);
        send(1, 64'h4,  R64, 3'd5, 5'd6, 1, 1, 0, 64'h0000_0000_0000_0001, 0);
        send(1, 64'h10, R64, 3'd7, 5'd7, 1, 1, 0, R64, 0);
        send(1, 64'h11, R64, 3'd2, 5'd8, 1, 1, 0, 64'h0000_0000_01F0_0000, 1);
        wait_drain(1);
        chk("cnt64_a", 256'({lc64, mc64}), 256'({32'd8, 32'd2}));

        // Backpressure: two entries fill the buffer, the third waits until WB drains.
        b64.wb_ready = 1'b0;
        send(1, 64'h100, R64, 3'd2, 5'd11, 1, 1, 0, 64'hFFFF_FFFF_F000_0002, 0);
        send(1, 64'h104, R64, 3'd2, 5'd12, 1, 1, 0, 64'hFFFF_FFFF_8000_0001, 0);
        chk("bp_ready_low", 256'(b64.mem_ready), 256'(0));
        fork
            send(1, 64'h200, 64'h0, 3'd0, 5'd13, 0, 1, 0, 64'h0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_wait", 256'(b64.mem_ready), 256'(0));
                b64.wb_ready = 1'b1;
            end
        join
        wait_drain(1);
        chk("cnt64_b", 256'({lc64, mc64}), 256'({32'd10, 32'd2}));

        // Flush collides with pop and accept while full.
        b64.wb_ready = 1'b0;
        send(1, 64'h300, R64, 3'd2, 5'd14, 1, 1, 0, 64'hFFFF_FFFF_F000_0002, 0);
        send(1, 64'h304, R64, 3'd6, 5'd15, 1, 1, 0, 64'h0000_0000_8000_0001, 0);
        flush = 1'b1;
        b64.wb_ready = 1'b1;
        b64.mem_valid = 1'b1;
        b64.mem_addr = 64'h400; b64.mem_funct3 = 3'd2; b64.mem_is_load = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        b64.mem_valid = 1'b0;
        q64.delete();
        chk("flush", 256'({b64.wb_valid, b64.mem_ready, lc64, mc64}), 256'({1'b0, 1'b1, 32'd10, 32'd2}));
        repeat (2) @(posedge clk);
        #1;
        chk("flush_idle", 256'(b64.wb_valid), 256'(0));

        // Asynchronous reset between edges while full.
        b64.wb_ready = 1'b0;
        send(1, 64'h500, R64, 3'd2, 5'd16, 1, 1, 0, 64'hFFFF_FFFF_F000_0002, 0);
        send(1, 64'h504, R64, 3'd2, 5'd17, 1, 1, 0, 64'hFFFF_FFFF_8000_0001, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_rst();
        q64.delete();
        @(negedge clk);
        reset = 1'b1;
        b64.wb_ready = 1'b1;
        @(posedge clk);
        #1;
        send(1, 64'h8, R64, 3'd3, 5'd20, 1, 1, 0, R64, 0);
        chk("lat_after_rst", 256'(b64.wb_valid), 256'(1));
        wait_drain(1);
        chk("cnt64_c", 256'({lc64, mc64}), 256'({32'd1, 32'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memwb_align_stage.md
# memwb_align_stage

- Parametrised MEM→WB pipeline stage for the scalar core.
- Aligns and sign- or zero-extends load data for XLEN 32 or 64, and detects misaligned loads.
- Decouples MEM and WB with a valid/ready handshake over a 2-entry skid buffer, replacing global stall hold.
- Keeps saturating load and misalign event counters for the CSR performance unit.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- CNT_W, 32: width of each event counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all buffered entries (trap/CSR redirect).
- mem_valid  in  1  MEM entry valid.
- mem_ready  out  1  stage can accept an entry this cycle.
- mem_addr  in  XLEN  ALU result: effective address for loads, rd value otherwise.
- mem_rdata  in  XLEN  raw, naturally aligned memory read word.
- mem_funct3  in  3  load type.
- mem_rd_addr  in  5  destination register.
- mem_is_load  in  1  entry is a load.
- mem_regwrite  in  1  integer register write.
- mem_f_regwrite  in  1  FP register write.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  WB consumes the head this cycle.
- wb_alu_data  out  XLEN  registered mem_addr.
- wb_load_data  out  XLEN  aligned/extended load result; 0 for non-loads.
- wb_rd_addr  out  5  destination register.
- wb_is_load  out  1  registered mem_is_load.
- wb_regwrite  out  1  qualified integer write.
- wb_f_regwrite  out  1  qualified FP write.
- wb_misalign  out  1  head is a misaligned load.
- load_cnt  out  CNT_W  loads retired.
- misalign_cnt  out  CNT_W  misaligned loads retired.

## Operation
- **Accept and pop.**
  - An input is accepted when mem_valid && mem_ready.
  - The head pops when wb_valid && wb_ready.
- **Occupancy state machine:** EMPTY, ONE, TWO.
  - EMPTY: accept → ONE, with the entry written to head.
  - ONE, accept and pop: stays ONE, new entry becomes head.
  - ONE, accept without pop: → TWO, new entry goes to skid.
  - ONE, pop without accept: → EMPTY.
  - TWO: pop → ONE, skid moves to head. Accept is impossible in TWO.
- **Ready signal.** mem_ready = (state != TWO). It is decoded from the state register only; there is no combinational path from wb_ready.
- **Load extraction** is done at accept time, before storage.
  - Byte offset off = mem_addr[log2(XLEN/8)-1:0].
  - funct3 0 LB: byte at off, sign-extended to XLEN.
  - funct3 4 LBU: byte at off, zero-extended to XLEN.
  - funct3 1 LH: halfword at off, sign-extended. Misaligned if off[0].
  - funct3 5 LHU: halfword at off, zero-extended. Misaligned if off[0].
  - funct3 2 LW: word at off, sign-extended to XLEN. Misaligned if off[1:0] != 0.
  - funct3 6 LWU (XLEN=64 only): word at off, zero-extended. Misaligned if off[1:0] != 0.
  - funct3 3 LD (XLEN=64 only): full rdata. Misaligned if off[2:0] != 0.
  - Any other funct3/XLEN combination: raw mem_rdata passes through, no misalign flag.
  - Non-loads: wb_load_data = 0 and wb_misalign = 0.
- **Write qualification.**
  - wb_regwrite = mem_regwrite && (mem_rd_addr != 0) && !misalign.
  - wb_f_regwrite = mem_f_regwrite && !misalign. FP x0 is writable.
- **Counters.**
  - On each pop with wb_is_load: load_cnt += 1.
  - If that entry also has wb_misalign: misalign_cnt += 1.
  - Both counters saturate at 2^CNT_W-1.
  - Counters are not cleared by flush.
- **Flush.**
  - State → EMPTY and both entry valid bits are cleared.
  - Flush overrides any simultaneous accept or pop, and counters do not count the popped entry that cycle.
  - Payload registers may keep stale data. wb_valid = 0 masks them.

## Timing
- Latency: an entry accepted in cycle N shows wb_valid = 1 in cycle N+1 if the buffer was EMPTY, or if ONE with a pop in cycle N.
- Throughput: 1 entry/cycle while wb_ready is held high.
- While wb_valid && !wb_ready, all wb_* outputs hold stable.
- After a flush in cycle N: wb_valid = 0 and mem_ready = 1 in cycle N+1.
- Reset (async assert, any state, mid-transfer included):
  - state = EMPTY, mem_ready = 1.
  - wb_valid, wb_regwrite, wb_f_regwrite, wb_is_load, wb_misalign = 0.
  - wb_alu_data, wb_load_data = 0; wb_rd_addr = 0.
  - load_cnt, misalign_cnt = 0.
- Deassertion of reset is synchronous to clk.

## Test plan
- **LB/LBU lanes.** XLEN=32, mem_rdata=0x80FF7F01, LB at addr 0x1003, then LBU at addr 0x1003 → wb_load_data = 0xFFFFFF80, then 0x00000080. One entry per cycle, latency 1.
- **LWU/LD on 64-bit.** XLEN=64, rdata=0x8000_0001_F000_0002:
  - LWU at addr 4 → 0x0000_0000_8000_0001.
  - LW at addr 0 → 0xFFFF_FFFF_F000_0002.
  - LD at addr 3 → wb_misalign=1, wb_regwrite=0, misalign_cnt=1 after pop.
- **Backpressure.** Hold wb_ready=0 and send 3 back-to-back entries → mem_ready drops after the 2nd accept, the 3rd entry waits, and the head is stable. Raise wb_ready → the 3 entries pop in order over 3 cycles with no loss or duplication.
- **x0 write.** regwrite=1, rd=0, LW → wb_regwrite=0 and load_cnt still increments. f_regwrite=1, rd=0 → wb_f_regwrite=1.
- **Flush collision.** In TWO state, flush together with wb_ready=1 and mem_valid=1 → next cycle wb_valid=0, mem_ready=1, counters unchanged.
- **Async reset mid-stream.** Assert reset between clock edges while in TWO → all outputs at their reset values immediately. The first entry after release appears one cycle after its accept.
